// File: rtl/seven_segments_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Hex font, blank pattern and a constant-width helper.
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low gfedcba pattern, index = hex nibble
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segments_scanner_if.sv
// Display bus: data/control from the debug source,
// scanned anode/segment pins back out to the board.
interface seven_segments_scanner_if #(
    parameter int DIGITS   = 3,
    parameter int BRIGHT_W = 3
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dots;
    logic [DIGITS-1:0]   blank_mask;
    logic                lz_blank;
    logic [BRIGHT_W-1:0] brightness;
    logic                load;
    logic [DIGITS-1:0]   anodes;
    logic [7:0]          segments;
    logic                frame_tick;

    modport master (
        output value, dots, blank_mask, lz_blank,
        output brightness, load,
        input  anodes, segments, frame_tick
    );

    modport slave (
        input  value, dots, blank_mask, lz_blank,
        input  brightness, load,
        output anodes, segments, frame_tick
    );
endinterface

// File: rtl/seven_segments_scanner_decoder.sv
// Nibble + decimal point to active-low segment byte.
// Purely combinational; dp lands in bit 7.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Font lookup with inverted decimal point
    always_comb begin
        seg = {~dp, HEX_FONT[nibble]};
    end

endmodule

// File: rtl/seven_segments_scanner.sv
// Multiplexed common-anode driver with PWM dimming,
// leading-zero suppression and frame-aligned updates.
module seven_segments_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000,
    parameter int BRIGHT_W = 3
) (
    input  logic clk,
    input  logic rst,
    seven_segments_scanner_if.slave bus
);

    localparam int PW     = clog2(SCAN_DIV);
    localparam int DW     = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int CW     = PW + 1;
    localparam int VW     = 4 * DIGITS;
    localparam int ON_LEN = SCAN_DIV >> BRIGHT_W;

    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);

    logic [PW-1:0]     p_q, p_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic              boundary;

    logic [VW-1:0]     sh_val_q, sh_val_d;
    logic [DIGITS-1:0] sh_dots_q, sh_dots_d;
    logic [DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic              sh_lz_q, sh_lz_d;

    logic [VW-1:0]     ds_val_q, ds_val_d;
    logic [DIGITS-1:0] ds_dots_q, ds_dots_d;
    logic [DIGITS-1:0] ds_blank_q, ds_blank_d;
    logic              ds_lz_q, ds_lz_d;

    logic [DIGITS-1:0] sup;
    logic              seen;
    logic [3:0]        cur_nib;
    logic              cur_dot;
    logic              cur_blank;
    logic              cur_sup;
    logic [7:0]        dec_seg;
    logic [CW-1:0]     on_lim;
    logic              lit;

    logic [DIGITS-1:0] anodes_q, anodes_d;
    logic [7:0]        segments_q, segments_d;
    logic              frame_tick_q, frame_tick_d;

    // Prescaler and digit index; digit advances on prescaler wrap
    always_comb begin
        p_d   = p_q + PW'(1);
        dig_d = dig_q;
        if (p_q == P_LAST) begin
            p_d = '0;
            if (dig_q == D_LAST) begin
                dig_d = '0;
            end else begin
                dig_d = dig_q + DW'(1);
            end
        end
    end

    assign boundary = (p_q == P_LAST) && (dig_q == D_LAST);

    // Shadow takes every load; display copies old shadow at frame end
    always_comb begin
        sh_val_d   = sh_val_q;
        sh_dots_d  = sh_dots_q;
        sh_blank_d = sh_blank_q;
        sh_lz_d    = sh_lz_q;
        if (bus.load) begin
            sh_val_d   = bus.value;
            sh_dots_d  = bus.dots;
            sh_blank_d = bus.blank_mask;
            sh_lz_d    = bus.lz_blank;
        end
        ds_val_d   = ds_val_q;
        ds_dots_d  = ds_dots_q;
        ds_blank_d = ds_blank_q;
        ds_lz_d    = ds_lz_q;
        if (boundary) begin
            ds_val_d   = sh_val_q;
            ds_dots_d  = sh_dots_q;
            ds_blank_d = sh_blank_q;
            ds_lz_d    = sh_lz_q;
        end
    end

    // Zero digits above the top nonzero one are suppressed; digit 0 never
    always_comb begin
        seen = 1'b0;
        sup  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen   = seen | (ds_val_q[4*i +: 4] != 4'h0);
            sup[i] = ds_lz_q & ~seen;
        end
    end

    // Pick the fields of the digit currently being scanned
    always_comb begin
        cur_nib   = '0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q == DW'(i)) begin
                cur_nib   = ds_val_q[4*i +: 4];
                cur_dot   = ds_dots_q[i];
                cur_blank = ds_blank_q[i];
                cur_sup   = sup[i];
            end
        end
    end

    seven_seg_decoder u_dec (
        .nibble (cur_nib),
        .dp     (cur_dot),
        .seg    (dec_seg)
    );

    // Brightness window; p=0 stays dark to hide ghosting on switch-over
    always_comb begin
        on_lim = CW'(ON_LEN) * (CW'(bus.brightness) + CW'(1));
        lit    = (p_q != '0) && ({1'b0, p_q} < on_lim) && !cur_blank;
    end

    // Next values of the registered display pins
    always_comb begin
        anodes_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lit && (dig_q == DW'(i))) begin
                anodes_d[i] = 1'b0;
            end
        end
        segments_d = dec_seg;
        if (cur_sup) begin
            segments_d[6:0] = SEG_OFF[6:0];
        end
        frame_tick_d = (p_q == '0) && (dig_q == '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q          <= '0;
            dig_q        <= '0;
            sh_val_q     <= '0;
            sh_dots_q    <= '0;
            sh_blank_q   <= '0;
            sh_lz_q      <= 1'b0;
            ds_val_q     <= '0;
            ds_dots_q    <= '0;
            ds_blank_q   <= '0;
            ds_lz_q      <= 1'b0;
            anodes_q     <= '1;
            segments_q   <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            dig_q        <= dig_d;
            sh_val_q     <= sh_val_d;
            sh_dots_q    <= sh_dots_d;
            sh_blank_q   <= sh_blank_d;
            sh_lz_q      <= sh_lz_d;
            ds_val_q     <= ds_val_d;
            ds_dots_q    <= ds_dots_d;
            ds_blank_q   <= ds_blank_d;
            ds_lz_q      <= ds_lz_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.segments   = segments_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segments_scanner.sv
// Bench for seven_segments_scanner: time-indexed reference
// model plus directed and randomized display scenarios.
module tb_seven_segments_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 16;
    localparam int BRIGHT_W = 2;
    localparam int ON_LEN   = 4;
    localparam int FRAME    = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_segments_scanner_if #(
        .DIGITS   (DIGITS),
        .BRIGHT_W (BRIGHT_W)
    ) bus ();

    seven_segments_scanner #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BRIGHT_W (BRIGHT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int last_tick = -1;

    logic [7:0] font [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int         t;
    logic [15:0] m_sh_val, m_ds_val;
    logic [3:0]  m_sh_dots, m_ds_dots;
    logic [3:0]  m_sh_blank, m_ds_blank;
    logic        m_sh_lz, m_ds_lz;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
    logic        exp_ft;

    int         meas_cnt [4];
    logic [7:0] meas_seg [4];

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input int d);
        int hi;
        logic [7:0] s;
        hi = -1;
        for (int i = 0; i < DIGITS; i++)
            if (m_ds_val[4*i +: 4] != 4'h0) hi = i;
        s = font[m_ds_val[4*d +: 4]];
        if (m_ds_lz && d != 0 && d > hi) s[6:0] = 7'h7F;
        s[7] = ~m_ds_dots[d];
        return s;
    endfunction

    task automatic tick();
        int p;
        int d;
        @(posedge clk);
        if (rst) begin
            exp_an = 4'hF;
            exp_seg = 8'hFF;
            exp_ft = 1'b0;
            t = 0;
            m_sh_val = '0; m_sh_dots = '0; m_sh_blank = '0; m_sh_lz = 1'b0;
            m_ds_val = '0; m_ds_dots = '0; m_ds_blank = '0; m_ds_lz = 1'b0;
            last_tick = -1;
        end else begin
            p = t % SCAN_DIV;
            d = (t / SCAN_DIV) % DIGITS;
            exp_ft = (t % FRAME == 0);
            exp_an = 4'hF;
            if (p != 0 && p < ON_LEN * (int'(bus.brightness) + 1)
                && !m_ds_blank[d])
                exp_an[d] = 1'b0;
            exp_seg = model_seg(d);
            if (t % FRAME == FRAME - 1) begin
                m_ds_val = m_sh_val; m_ds_dots = m_sh_dots;
                m_ds_blank = m_sh_blank; m_ds_lz = m_sh_lz;
            end
            if (bus.load) begin
                m_sh_val = bus.value; m_sh_dots = bus.dots;
                m_sh_blank = bus.blank_mask; m_sh_lz = bus.lz_blank;
            end
            t++;
        end
        @(negedge clk);
        cyc++;
        check("anodes", {4'h0, bus.anodes}, {4'h0, exp_an});
        check("segments", bus.segments, exp_seg);
        check("frame_tick", {7'h0, bus.frame_tick}, {7'h0, exp_ft});
        if (bus.frame_tick) begin
            if (last_tick >= 0)
                check("tick_period", 8'(cyc - last_tick), 8'(FRAME));
            last_tick = cyc;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dt,
                           input logic [3:0] bm, input logic lz);
        bus.value = v;
        bus.dots = dt;
        bus.blank_mask = bm;
        bus.lz_blank = lz;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int g;
        g = 0;
        while (t % FRAME != pos && g < 2 * FRAME) begin
            tick();
            g++;
        end
        if (t % FRAME != pos) check("pos_wait", 8'(t % FRAME), 8'(pos));
    endtask

    task automatic measure();
        int g;
        g = 0;
        for (int i = 0; i < DIGITS; i++) begin
            meas_cnt[i] = 0;
            meas_seg[i] = 8'h00;
        end
        while (!bus.frame_tick && g < FRAME + 8) begin
            tick();
            g++;
        end
        if (!bus.frame_tick) check("frame_wait", 8'h00, 8'h01);
        for (int k = 0; k < FRAME; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (!bus.anodes[i]) begin
                    meas_cnt[i]++;
                    meas_seg[i] = bus.segments;
                end
            end
            if (k < FRAME - 1) tick();
        end
    endtask

    task automatic expect_frame(input string tag, input int on,
                                input logic [31:0] segs);
        for (int i = 0; i < DIGITS; i++) begin
            check($sformatf("%s_on_d%0d", tag, i), 8'(meas_cnt[i]), 8'(on));
            check($sformatf("%s_seg_d%0d", tag, i), meas_seg[i],
                  segs[8*i +: 8]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.value = '0;
        bus.dots = '0;
        bus.blank_mask = '0;
        bus.lz_blank = 1'b0;
        bus.brightness = 2'd3;
        bus.load = 1'b0;

        repeat (3) tick();
        check("rst_anodes", {4'h0, bus.anodes}, 8'h0F);
        check("rst_segments", bus.segments, 8'hFF);
        check("rst_tick", {7'h0, bus.frame_tick}, 8'h00);
        rst = 1'b0;
        tick();
        check("first_tick", {7'h0, bus.frame_tick}, 8'h01);
        repeat (2 * FRAME) tick();

        do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
        measure();
        measure();
        expect_frame("full", 15, 32'hF9A4888E);

        bus.brightness = 2'd0;
        measure();
        expect_frame("dim0", 3, 32'hF9A4888E);
        bus.brightness = 2'd1;
        measure();
        expect_frame("dim1", 7, 32'hF9A4888E);
        bus.brightness = 2'd3;

        do_load(16'h0050, 4'b1000, 4'h0, 1'b1);
        measure();
        measure();
        expect_frame("lz", 15, 32'h7FFF92C0);
        do_load(16'h0000, 4'b0000, 4'h0, 1'b1);
        measure();
        measure();
        expect_frame("lz0", 15, 32'hFFFFFFC0);

        do_load(16'h3333, 4'h0, 4'h0, 1'b0);
        measure();
        measure();
        expect_frame("pre", 15, 32'hB0B0B0B0);
        wait_pos(2 * SCAN_DIV + 5);
        do_load(16'h1111, 4'h0, 4'h0, 1'b0);
        tick();
        check("midframe_hold", bus.segments, 8'hB0);
        measure();
        expect_frame("midload", 15, 32'hF9F9F9F9);

        wait_pos(FRAME - 1);
        do_load(16'h2222, 4'h0, 4'h0, 1'b0);
        measure();
        expect_frame("bnd_old", 15, 32'hF9F9F9F9);
        measure();
        expect_frame("bnd_new", 15, 32'hA4A4A4A4);

        wait_pos(SCAN_DIV + 9);
        rst = 1'b1;
        tick();
        check("midrst_anodes", {4'h0, bus.anodes}, 8'h0F);
        check("midrst_segments", bus.segments, 8'hFF);
        rst = 1'b0;
        tick();
        check("rel_dead", {4'h0, bus.anodes}, 8'h0F);
        tick();
        check("rel_first_an", {4'h0, bus.anodes}, 8'h0E);
        check("rel_first_seg", bus.segments, 8'hC0);

        for (int n = 0; n < 3000; n++) begin
            bus.load = ($urandom_range(0, 15) == 0);
            bus.value = 16'($urandom);
            bus.dots = 4'($urandom);
            bus.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.lz_blank = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bus.brightness = 2'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
